gshare_predictor: RTL and testbench
===================================

# gshare_predictor

Global-history branch direction predictor that sits directly upstream of the 2-bit saturating counter stage. It owns a 128-entry pattern history table (PHT) of 2-bit counters and a 7-bit global history register (GHR), and indexes the PHT with PC XOR GHR. It answers prediction lookups in the same cycle. It applies resolved-branch training to the selected counter and repairs the history on a misprediction.

## Interface
- PC_W, 7, width of the branch PC index bits.
- HIST_W, 7, global history length; must equal PC_W (PHT depth = 2**PC_W).
- clk  in  1  single clock, rising edge.
- areset_n  in  1  asynchronous, active-low reset.
- predict_valid  in  1  lookup request this cycle.
- predict_pc  in  PC_W  PC of the branch being predicted.
- predict_taken  out  1  predicted direction (combinational).
- predict_history  out  HIST_W  GHR value used for this lookup (combinational); the consumer carries it to training.
- train_valid  in  1  resolved branch this cycle.
- train_taken  in  1  actual outcome.
- train_mispredicted  in  1  resolved outcome differed from the prediction.
- train_history  in  HIST_W  history captured at prediction time.
- train_pc  in  PC_W  PC of the resolved branch.

## Operation
- Predict index = predict_pc ^ GHR.
- predict_taken = PHT[index][1].
- predict_history = GHR.
- Outputs are valid regardless of predict_valid; the consumer qualifies them.
- Train index = train_pc ^ train_history.
- Counter update when train_valid = 1:
  - train_taken = 1: +1, saturating at 3.
  - train_taken = 0: -1, saturating at 0.
- GHR update, priority order:
  1. train_valid and train_mispredicted: GHR <= {train_history[HIST_W-2:0], train_taken}.
  2. Otherwise, if predict_valid: GHR <= {GHR[HIST_W-2:0], predict_taken}.
  3. Otherwise GHR holds.
- A mispredict recovery discards any same-cycle speculative shift.
- Correctly predicted training never modifies GHR.
- Arithmetic is all unsigned. Index XOR is width PC_W with no carry, so wrap-around is inherent.

## Timing
- Reset, asserted asynchronously on areset_n = 0:
  - all PHT entries = 2'b01 (weakly not-taken);
  - GHR = 0;
  - hence predict_taken = 0 and predict_history = 0 immediately.
- Reset mid-operation discards all state. The first edge after deassertion behaves as normal operation.
- Prediction latency is 0 cycles: combinational from predict_pc and current state.
- Training takes effect at the next rising edge and is visible to lookups from the following cycle.
- Simultaneous train and predict on the same PHT index in one cycle: the prediction sees the pre-update counter (read-before-write). The counter still updates at the edge.
- Simultaneous train (no mispredict) and predict: both the PHT write and the GHR shift occur at the same edge.
- There is no backpressure and no handshake stall. Every valid cycle is consumed.

## Structure
- Package bp_pkg holds:
  - PC_W / HIST_W defaults;
  - typedef ctr2_t (logic [1:0]);
  - constant CTR_RESET = 2'b01;
  - function ctr_next(ctr2_t c, logic taken) implementing the saturating update. The downstream counter stage reuses the same function.
- One sub-module, bp_pht, holds:
  - the 2**PC_W x ctr2_t array with async reset;
  - one combinational read port (rd_idx, rd_ctr);
  - one write-enabled update port (wr_en, wr_idx, wr_taken) using ctr_next.
- gshare_predictor contains the GHR, the index XORs and the GHR priority mux.

## Test plan
- Reset: hold areset_n = 0, then release. Expect predict_taken = 0 and predict_history = 0 for every predict_pc. Expect PHT[0x00] and PHT[0x7F] to read 2'b01.
- Saturation: 4 trainings on pc = 0x12, history = 0, taken = 1, mispredicted = 0. Expect counter 1→2→3→3. Then 5 not-taken trainings: 3→2→1→0→0. Expect predict_taken to flip to 1 after the first taken training.
- Speculative history: predict_valid for 3 cycles with outcomes 0,1,1 (PHT preloaded by training). Expect GHR = 0b0000011, and predict_history to match each cycle.
- Mispredict recovery: GHR = 0x55. train_valid = 1, train_mispredicted = 1, train_history = 0x2A, train_taken = 1, with predict_valid = 1 in the same cycle. Expect next GHR = 0x55 (0x2A shifted, LSB 1). Expect no speculative bit.
- Index aliasing / same-cycle hazard: predict and train the same index (pc = 0x10 with GHR = 0x03; train_pc = 0x13, train_history = 0). Counter is at 1 and train_taken = 1. Expect predict_taken = 0 that cycle and 1 the next cycle.
- Async reset mid-stream: assert areset_n = 0 between edges during active training. Expect outputs to clear immediately, without waiting for clk, and the in-flight training to be lost.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared branch-predictor types, defaults and the 2-bit saturating counter update.
package bp_pkg;

   localparam int unsigned DEF_PC_W   = 7;
   localparam int unsigned DEF_HIST_W = 7;

   typedef logic [1:0] ctr2_t;

   // Weakly not-taken
   localparam ctr2_t CTR_RESET = 2'b01;

   // Saturating increment on taken, saturating decrement on not-taken
   function automatic ctr2_t ctr_next(ctr2_t c, logic taken);
      ctr2_t n;
      n = c;
      if (taken) begin
         if (c != 2'b11) n = c + 2'd1;
      end else begin
         if (c != 2'b00) n = c - 2'd1;
      end
      return n;
   endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table: 2**PC_W two-bit counters, one async read port, one update port.
module bp_pht
   import bp_pkg::*;
#(
   parameter int unsigned PC_W = DEF_PC_W
) (
   input  logic            clk,
   input  logic            areset_n,
   input  logic [PC_W-1:0] rd_idx,
   output ctr2_t           rd_ctr,
   input  logic            wr_en,
   input  logic [PC_W-1:0] wr_idx,
   input  logic            wr_taken
);

   localparam int unsigned DEPTH = 1 << PC_W;

   ctr2_t pht_q [DEPTH];
   ctr2_t pht_d [DEPTH];

   // Read sees the pre-update counter, so a same-cycle write is invisible until next cycle
   always_comb begin
      rd_ctr = pht_q[rd_idx];
   end

   // Next-state: only the addressed counter moves
   always_comb begin
      pht_d = pht_q;
      if (wr_en) begin
         pht_d[wr_idx] = ctr_next(pht_q[wr_idx], wr_taken);
      end
   end

   // Counter storage, all entries return to weakly not-taken on reset
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            pht_q[i] <= CTR_RESET;
         end
      end else begin
         pht_q <= pht_d;
      end
   end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: GHR xor PC indexes the PHT; misprediction repairs the GHR.
module gshare_predictor
   import bp_pkg::*;
#(
   parameter int unsigned PC_W   = DEF_PC_W,
   // Must equal PC_W so the XOR index covers the whole table
   parameter int unsigned HIST_W = DEF_HIST_W
) (
   input  logic              clk,
   input  logic              areset_n,
   input  logic              predict_valid,
   input  logic [PC_W-1:0]   predict_pc,
   output logic              predict_taken,
   output logic [HIST_W-1:0] predict_history,
   input  logic              train_valid,
   input  logic              train_taken,
   input  logic              train_mispredicted,
   input  logic [HIST_W-1:0] train_history,
   input  logic [PC_W-1:0]   train_pc
);

   logic [HIST_W-1:0] ghr_q, ghr_d;
   logic [PC_W-1:0]   pred_idx;
   logic [PC_W-1:0]   train_idx;
   ctr2_t             pred_ctr;

   // Index hashing and combinational prediction outputs
   always_comb begin
      pred_idx        = predict_pc ^ ghr_q;
      train_idx       = train_pc ^ train_history;
      predict_taken   = pred_ctr[1];
      predict_history = ghr_q;
   end

   bp_pht #(
      .PC_W (PC_W)
   ) u_pht (
      .clk      (clk),
      .areset_n (areset_n),
      .rd_idx   (pred_idx),
      .rd_ctr   (pred_ctr),
      .wr_en    (train_valid),
      .wr_idx   (train_idx),
      .wr_taken (train_taken)
   );

   // GHR: mispredict repair beats the speculative shift; otherwise hold
   always_comb begin
      ghr_d = ghr_q;
      if (train_valid && train_mispredicted) begin
         ghr_d = {train_history[HIST_W-2:0], train_taken};
      end else if (predict_valid) begin
         ghr_d = {ghr_q[HIST_W-2:0], predict_taken};
      end
   end

   // GHR register
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         ghr_q <= '0;
      end else begin
         ghr_q <= ghr_d;
      end
   end

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor: directed vector table, hand sequences, random vs model.
module tb_gshare_predictor;

   logic       clk;
   logic       areset_n;
   logic       predict_valid;
   logic [6:0] predict_pc;
   logic       predict_taken;
   logic [6:0] predict_history;
   logic       train_valid;
   logic       train_taken;
   logic       train_mispredicted;
   logic [6:0] train_history;
   logic [6:0] train_pc;

   gshare_predictor #(
      .PC_W   (7),
      .HIST_W (7)
   ) dut (
      .clk                (clk),
      .areset_n           (areset_n),
      .predict_valid      (predict_valid),
      .predict_pc         (predict_pc),
      .predict_taken      (predict_taken),
      .predict_history    (predict_history),
      .train_valid        (train_valid),
      .train_taken        (train_taken),
      .train_mispredicted (train_mispredicted),
      .train_history      (train_history),
      .train_pc           (train_pc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: counters as plain integers 0..3, history as an integer 0..127
   int          m_pht [128];
   int unsigned m_ghr;

   typedef struct {
      logic       pv;
      logic [6:0] pc;
      logic       tv;
      logic       tt;
      logic       tm;
      logic [6:0] th;
      logic [6:0] tpc;
      logic       exp_taken;
      logic [6:0] exp_hist;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int m_pred(input logic [6:0] pc);
      return (m_pht[(int'(pc) ^ m_ghr) % 128] >= 2) ? 1 : 0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 128; i++) m_pht[i] = 1;
      m_ghr = 0;
   endtask

   task automatic drive(input logic pv, input logic [6:0] pc, input logic tv, input logic tt,
                        input logic tm, input logic [6:0] th, input logic [6:0] tpc);
      predict_valid      = pv;
      predict_pc         = pc;
      train_valid        = tv;
      train_taken        = tt;
      train_mispredicted = tm;
      train_history      = th;
      train_pc           = tpc;
   endtask

   task automatic check_model(input string name);
      check({name, "_taken"}, {31'd0, predict_taken}, m_pred(predict_pc));
      check({name, "_hist"}, {25'd0, predict_history}, m_ghr);
   endtask

   // Called between negedge and posedge: computes model next state, crosses the edge
   task automatic advance();
      int unsigned nghr;
      int          idx;
      int          pt;
      logic        tv, tt;
      pt  = m_pred(predict_pc);
      tv  = train_valid;
      tt  = train_taken;
      idx = int'(train_pc ^ train_history);
      if (train_valid && train_mispredicted)
         nghr = (int'(train_history) * 2 + int'(train_taken)) % 128;
      else if (predict_valid)
         nghr = (m_ghr * 2 + pt) % 128;
      else
         nghr = m_ghr;
      @(posedge clk);
      if (tv) begin
         if (tt) m_pht[idx] = (m_pht[idx] < 3) ? m_pht[idx] + 1 : 3;
         else    m_pht[idx] = (m_pht[idx] > 0) ? m_pht[idx] - 1 : 0;
      end
      m_ghr = nghr;
      #1;
   endtask

   task automatic do_reset();
      logic [6:0] pcs [4];
      pcs[0] = 7'h00; pcs[1] = 7'h7F; pcs[2] = 7'h12; pcs[3] = 7'h55;
      drive(0, 0, 0, 0, 0, 0, 0);
      areset_n = 1'b0;
      model_reset();
      for (int i = 0; i < 4; i++) begin
         predict_pc = pcs[i];
         #1;
         check("rst_taken", {31'd0, predict_taken}, 0);
         check("rst_hist", {25'd0, predict_history}, 0);
      end
      @(posedge clk);
      @(negedge clk);
      areset_n = 1'b1;
      predict_pc = 7'h00;
      @(posedge clk);
      #1;
   endtask

   task automatic add_vec(input logic pv, input logic [6:0] pc, input logic tv, input logic tt,
                          input logic tm, input logic [6:0] th, input logic [6:0] tpc,
                          input logic et, input logic [6:0] eh);
      vecs.push_back('{pv, pc, tv, tt, tm, th, tpc, et, eh});
   endtask

   initial begin
      areset_n = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      model_reset();
      #2;

      // Saturation on pc 0x12: 1->2->3->3 then 3->2->1->0->0, then climb back
      add_vec(0, 7'h12, 1, 1, 0, 7'h00, 7'h12, 0, 7'h00);
      add_vec(0, 7'h12, 1, 1, 0, 7'h00, 7'h12, 1, 7'h00);
      add_vec(0, 7'h12, 1, 1, 0, 7'h00, 7'h12, 1, 7'h00);
      add_vec(0, 7'h12, 1, 1, 0, 7'h00, 7'h12, 1, 7'h00);
      add_vec(0, 7'h12, 1, 0, 0, 7'h00, 7'h12, 1, 7'h00);
      add_vec(0, 7'h12, 1, 0, 0, 7'h00, 7'h12, 1, 7'h00);
      add_vec(0, 7'h12, 1, 0, 0, 7'h00, 7'h12, 0, 7'h00);
      add_vec(0, 7'h12, 1, 0, 0, 7'h00, 7'h12, 0, 7'h00);
      add_vec(0, 7'h12, 1, 0, 0, 7'h00, 7'h12, 0, 7'h00);
      add_vec(0, 7'h12, 0, 0, 0, 7'h00, 7'h12, 0, 7'h00);
      add_vec(0, 7'h12, 1, 1, 0, 7'h00, 7'h12, 0, 7'h00);
      add_vec(0, 7'h12, 1, 1, 0, 7'h00, 7'h12, 0, 7'h00);
      add_vec(0, 7'h12, 0, 0, 0, 7'h00, 7'h12, 1, 7'h00);
      // Speculative history: outcomes 0,1,1 (PHT[0x12] now 2) -> GHR 0b0000011
      add_vec(1, 7'h20, 0, 0, 0, 7'h00, 7'h00, 0, 7'h00);
      add_vec(1, 7'h12, 0, 0, 0, 7'h00, 7'h00, 1, 7'h00);
      add_vec(1, 7'h13, 0, 0, 0, 7'h00, 7'h00, 1, 7'h01);
      add_vec(0, 7'h00, 0, 0, 0, 7'h00, 7'h00, 0, 7'h03);

      do_reset();
      foreach (vecs[i]) begin
         drive(vecs[i].pv, vecs[i].pc, vecs[i].tv, vecs[i].tt, vecs[i].tm, vecs[i].th,
               vecs[i].tpc);
         @(negedge clk);
         check($sformatf("vec%0d_taken", i), {31'd0, predict_taken}, {31'd0, vecs[i].exp_taken});
         check($sformatf("vec%0d_hist", i), {25'd0, predict_history}, {25'd0, vecs[i].exp_hist});
         advance();
      end

      // Mispredict recovery with a concurrent predict: no speculative bit survives
      do_reset();
      drive(0, 7'h00, 1, 1, 1, 7'h6A, 7'h00);
      @(negedge clk); advance();
      drive(1, 7'h01, 1, 1, 1, 7'h2A, 7'h00);
      @(negedge clk);
      check("mp_pre_hist", {25'd0, predict_history}, 32'h55);
      advance();
      drive(0, 7'h00, 0, 0, 0, 7'h00, 7'h00);
      @(negedge clk);
      check("mp_post_hist", {25'd0, predict_history}, 32'h55);
      check_model("mp_post");
      drive(1, 7'h01, 1, 0, 1, 7'h0F, 7'h00);
      @(negedge clk); advance();
      drive(0, 7'h00, 0, 0, 0, 7'h00, 7'h00);
      @(negedge clk);
      check("mp2_hist", {25'd0, predict_history}, 32'h1E);
      advance();

      // Same-index predict and train: prediction sees the old counter
      do_reset();
      drive(0, 7'h00, 1, 1, 1, 7'h01, 7'h40);
      @(negedge clk); advance();
      drive(1, 7'h10, 1, 1, 0, 7'h00, 7'h13);
      @(negedge clk);
      check("hz_same_taken", {31'd0, predict_taken}, 0);
      check("hz_same_hist", {25'd0, predict_history}, 32'h03);
      advance();
      drive(0, 7'h15, 0, 0, 0, 7'h00, 7'h00);
      @(negedge clk);
      check("hz_next_taken", {31'd0, predict_taken}, 1);
      check("hz_next_hist", {25'd0, predict_history}, 32'h06);
      advance();

      // Async reset between edges while a training is in flight
      drive(0, 7'h15, 1, 1, 0, 7'h00, 7'h13);
      #2;
      areset_n = 1'b0;
      #1;
      check("ar_taken", {31'd0, predict_taken}, 0);
      check("ar_hist", {25'd0, predict_history}, 0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      areset_n = 1'b1;
      drive(0, 7'h13, 0, 0, 0, 7'h00, 7'h00);
      #1;
      check("ar_lost_taken", {31'd0, predict_taken}, 0);
      @(posedge clk); #1;
      drive(1, 7'h13, 1, 1, 0, 7'h00, 7'h13);
      @(negedge clk); advance();
      drive(0, 7'h13 ^ m_ghr[6:0], 0, 0, 0, 7'h00, 7'h00);
      @(negedge clk);
      check("ar_one_train", {31'd0, predict_taken}, 1);
      advance();

      // Random traffic against the model
      for (int n = 0; n < 3000; n++) begin
         drive($urandom_range(0, 1), 7'($urandom), $urandom_range(0, 1), $urandom_range(0, 1),
               ($urandom_range(0, 3) == 0), 7'($urandom),
               ($urandom_range(0, 1) == 1) ? 7'($urandom_range(0, 7)) : 7'($urandom));
         @(negedge clk);
         check_model("rand");
         advance();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
